// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and counter sizing for the bit-serial adder
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // A 1-bit counter is still needed when the operand width is very small.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fa_1bit.sv
// rtl/fa_1bit.sv - combinational full-adder cell, time-shared by the serial sequencer
module fa_1bit (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial N-bit adder sequencer with start/done handshake
// Optional subtract mode (sub port) is built when SERIAL_SUB_EN is defined.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
`ifdef SERIAL_SUB_EN
   input  logic         sub,
`endif
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout
);

   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    a_sh_q, a_sh_d;
   logic [N-1:0]    b_sh_q, b_sh_d;
   // Only N-1 result bits are stored: the final bit comes straight from the cell.
   logic [N-2:0]    res_q, res_d;
   logic            carry_q, carry_d;
   logic [N-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;

   logic            sub_i;
   logic            fa_sum, fa_carry;
   logic [N-1:0]    res_shift;
   logic            accept;

`ifdef SERIAL_SUB_EN
   assign sub_i = sub;
`else
   assign sub_i = 1'b0;
`endif

   fa_1bit u_fa (
      .a     (a_sh_q[0]),
      .b     (b_sh_q[0]),
      .c     (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   assign res_shift = {fa_sum, res_q};
   assign accept    = start && ((state_q == IDLE) || (state_q == DONE));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            res_d   = res_shift[N-1:1];
            carry_d = fa_carry;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
               sum_d   = res_shift;
               cout_d  = fa_carry;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = accept ? RUN : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Subtraction is a + ~b + 1, so invert B and force the carry at capture.
      if (accept) begin
         a_sh_d  = a;
         b_sh_d  = sub_i ? ~b : b;
         carry_d = sub_i ? 1'b1 : cin;
         res_d   = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl at N=4 and N=8
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       start4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, cout4;
   logic [3:0] sum4;
   logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   int nvec = 0, nerr = 0, cyc = 0;
   bit checking = 1'b0;

   // Transaction-level model: remaining run cycles, pending total, visible result.
   int         run_left [2];
   logic [8:0] pend     [2];
   logic [8:0] res_m    [2];
   bit         done_m   [2];

   serial_add_ctrl #(.N(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef SERIAL_SUB_EN
      .sub   (sub4),
`endif
      .start (start4),
      .a     (a4),
      .b     (b4),
      .cin   (cin4),
      .busy  (busy4),
      .done  (done4),
      .sum   (sum4),
      .cout  (cout4)
   );

   serial_add_ctrl #(.N(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef SERIAL_SUB_EN
      .sub   (sub8),
`endif
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
   );

   function automatic logic [8:0] exp_total(input int n, input logic [7:0] a, input logic [7:0] b,
                                            input logic c, input logic s);
      int mask;
      int t;
      mask = (1 << n) - 1;
`ifdef SERIAL_SUB_EN
      if (s) t = int'(a) + (int'(~b) & mask) + 1;
      else   t = int'(a) + int'(b) + int'(c);
`else
      t = int'(a) + int'(b) + int'(c) + (int'(s) & 0);
`endif
      return 9'(t & ((mask << 1) | 1));
   endfunction

   task automatic model_step(input int u, input logic st, input logic [8:0] tot, input int n);
      if (!rst_n) begin
         run_left[u] = 0;
         done_m[u]   = 1'b0;
         res_m[u]    = '0;
      end else if (run_left[u] > 0) begin
         run_left[u] = run_left[u] - 1;
         done_m[u]   = (run_left[u] == 0);
         if (done_m[u]) res_m[u] = pend[u];
      end else begin
         done_m[u] = 1'b0;
         if (st) begin
            pend[u]     = tot;
            run_left[u] = n;
         end
      end
   endtask

   always @(posedge clk) begin
      cyc = cyc + 1;
      model_step(0, start4, exp_total(4, {4'b0, a4}, {4'b0, b4}, cin4, sub4), 4);
      model_step(1, start8, exp_total(8, a8, b8, cin8, sub8), 8);
   end

   task automatic cmp_unit(input string nm, input int u, input logic busy, input logic done,
                           input logic [8:0] got);
      nvec++;
      if (busy !== (run_left[u] > 0) || done !== done_m[u] || got !== res_m[u]) begin
         nerr++;
         $display("FAIL %s cyc=%0d got busy=%b done=%b res=%h want busy=%b done=%b res=%h",
                  nm, cyc, busy, done, got, (run_left[u] > 0), done_m[u], res_m[u]);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         cmp_unit("dut4_cycle", 0, busy4, done4, {4'b0, cout4, sum4});
         cmp_unit("dut8_cycle", 1, busy8, done8, {cout8, sum8});
      end
   end

   task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   // Called at a negedge while the unit is idle or in DONE; returns at the done negedge.
   task automatic run_op(input int u, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic s, output logic [8:0] r, output int lat);
      int t0;
      bit seen;
      seen = 1'b0;
      if (u == 0) begin start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; cin4 = c; sub4 = s; end
      else        begin start8 = 1'b1; a8 = a;      b8 = b;      cin8 = c; sub8 = s; end
      @(negedge clk);
      t0 = cyc;
      if (u == 0) begin
         start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
         cin4 = 1'($urandom); sub4 = 1'($urandom);
      end else begin
         start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
         cin8 = 1'($urandom); sub8 = 1'($urandom);
      end
      r   = 'x;
      lat = -1;
      for (int i = 0; i < 20 && !seen; i++) begin
         if ((u == 0 && done4 === 1'b1) || (u == 1 && done8 === 1'b1)) begin
            seen = 1'b1;
            lat  = cyc - t0;
            r    = (u == 0) ? {4'b0, cout4, sum4} : {cout8, sum8};
         end else begin
            @(negedge clk);
         end
      end
      if (!seen) begin
         nvec++;
         nerr++;
         $display("FAIL timeout_unit%0d got no done want done", u);
      end
   endtask

   initial begin
      logic [8:0] r;
      int         lat;
      int         d;
      int         td [2];
      bit         sawd;
      logic [7:0] ra, rb;
      logic       rc;
      logic [8:0] w;

      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      checking = 1'b1;
      lit("reset_busy", {31'b0, busy4}, 0);
      lit("reset_done", {31'b0, done4}, 0);
      lit("reset_result", {27'b0, cout4, sum4}, 0);

      run_op(0, 8'd7, 8'd5, 1'b0, 1'b0, r, lat);
      lit("t1_result", r, 9'h00C);
      lit("t1_latency", lat, 4);
      run_op(0, 8'hF, 8'h1, 1'b0, 1'b0, r, lat);
      lit("t2a_result", r, 9'h010);
      run_op(0, 8'hF, 8'hF, 1'b1, 1'b0, r, lat);
      lit("t2b_result", r, 9'h01F);

      @(negedge clk);
      start4 = 1'b1; a4 = 4'd3; b4 = 4'd4; cin4 = 1'b0; sub4 = 1'b0;
      @(negedge clk);
      a4 = 4'd1; b4 = 4'd1;
      d = 0;
      for (int i = 0; i < 30 && d < 2; i++) begin
         @(negedge clk);
         if (done4 === 1'b1) begin
            td[d] = cyc;
            if (d == 0) lit("t3_first", {27'b0, cout4, sum4}, 7);
            else begin
               lit("t3_second", {27'b0, cout4, sum4}, 2);
               start4 = 1'b0;
            end
            d++;
         end else if (d == 1) begin
            a4 = 4'd9; b4 = 4'd9;
         end
      end
      if (d < 2) begin
         nvec++; nerr++;
         $display("FAIL t3_dones got=%0d want=2", d);
      end else begin
         lit("t3_spacing", td[1] - td[0], 5);
      end

      @(negedge clk);
      start4 = 1'b1; a4 = 4'd9; b4 = 4'd9; cin4 = 1'b0;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0; start4 = 1'b1;
      @(negedge clk);
      rst_n = 1'b1; start4 = 1'b0;
      lit("t4_busy", {31'b0, busy4}, 0);
      lit("t4_done", {31'b0, done4}, 0);
      lit("t4_result", {27'b0, cout4, sum4}, 0);
      sawd = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done4 !== 1'b0) sawd = 1'b1;
      end
      lit("t4_no_done", {31'b0, sawd}, 0);
      run_op(0, 8'd2, 8'd2, 1'b0, 1'b0, r, lat);
      lit("t4_restart", r, 9'h004);

      for (int k = 0; k < 10; k++) begin
         ra = 8'($random);
         rb = 8'($random);
         rc = 1'($random);
         w  = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
         run_op(1, ra, rb, rc, 1'b0, r, lat);
         lit("t5_result", r, w);
         lit("t5_latency", lat, 8);
      end

`ifdef SERIAL_SUB_EN
      run_op(0, 8'd5, 8'd3, 1'b0, 1'b1, r, lat);
      lit("t6_sub_5_3", r, 9'h012);
      run_op(0, 8'd3, 8'd5, 1'b0, 1'b1, r, lat);
      lit("t6_sub_3_5", r, 9'h00E);
      run_op(0, 8'd5, 8'd3, 1'b0, 1'b0, r, lat);
      lit("t6_add_5_3", r, 9'h008);
      run_op(0, 8'd3, 8'd5, 1'b0, 1'b0, r, lat);
      lit("t6_add_3_5", r, 9'h008);
`endif

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial N-bit adder sequencer: time-shares one 1-bit full-adder cell over N clock cycles to add two N-bit operands plus carry-in.
- Start/done handshake to a host; result registers hold the last result until the next operation completes.
- Sits beside the combinational full-adder datapath as its low-area alternative; the sequencing FSM, operand shift registers and carry flop live here.

Parameters:
- N, 4, operand/result width in bits (N >= 2); counter width is derived internally as $clog2(N).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  request pulse; sampled only when ready (state IDLE or DONE)
- a  input  N  operand A, captured on accepted start
- b  input  N  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, high during the DONE state
- sum  output  N  registered result
- cout  output  1  registered carry-out

Behaviour:
- Reset: rst_n low at a rising edge forces state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, shift registers=0, carry flop=0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 captures a, b and cin into the shift registers and carry flop; counter=0; go to RUN.
  - RUN: each cycle the cell adds the LSB of A, the LSB of B and the carry flop. The sum bit shifts into the MSB of the result shift register, and A and B shift right by 1. The carry flop takes the cell carry-out. The counter increments.
  - RUN exit: on the edge where counter==N-1, the final bit is processed, sum and cout are loaded from the result register and carry, and the state goes to DONE.
  - DONE: done=1 for exactly one cycle. start=1 in this cycle is accepted: same capture as IDLE, next state RUN (back-to-back operation). Otherwise the next state is IDLE.
- Latency: start accepted at edge 0 gives busy=1 after edges 0..N-1, and done=1 with a valid sum/cout after edge N. Throughput is one result per N+1 cycles.
- Outputs: sum/cout change only on entry to DONE and hold otherwise, including through IDLE.
- start during RUN is ignored; it is not queued and operands are not re-sampled.
- Operand inputs are don't-care except at the accepting edge.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(N+1). No truncation.
- Reset mid-RUN aborts the operation: no done pulse, and sum/cout return to 0.
- rst_n low and start high at the same edge: reset wins.

Optional Feature:
- Macro SERIAL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - When sub=1, B is inverted bit-wise at capture and the carry flop is loaded with 1, ignoring cin. The result is then sum = a - b (mod 2^N), and cout = 1 means no borrow.
  - When sub=0, behaviour is identical to the non-macro build.
- Not defined: no sub port; add-only behaviour.

Decomposition:
- Shared package serial_add_pkg:
  - state enum type (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - localparam function for the counter width.
- Sub-module fa_1bit (ports a, b, c, sum, carry; purely combinational) is the time-shared cell, instantiated once. All sequencing stays in serial_add_ctrl.

Test Plan:
- N=4, a=4'b0111, b=4'b0101, cin=0, start pulse:
  - busy high for 4 cycles; done pulse on the 5th; sum=4'b1100, cout=0.
- N=4, a=4'hF, b=4'h1, cin=0 gives sum=4'h0, cout=1. Then a=4'hF, b=4'hF, cin=1 gives sum=4'hF, cout=1.
- Hold start high continuously with a=3, b=4, then a=1, b=1, changing operands mid-RUN:
  - only the captures in IDLE/DONE are used;
  - results are 7 then 2;
  - done pulses exactly 5 cycles apart;
  - mid-RUN operand changes have no effect.
- Pulse rst_n low for 1 cycle at RUN cycle 2 of a=9, b=9:
  - next cycle shows busy=0, done=0, sum=0, cout=0;
  - no done pulse follows;
  - a fresh start with a=2, b=2 then yields 4.
- N=8, 10 random {a,b,cin} via $random:
  - each {cout,sum} equals a+b+cin;
  - done asserted exactly 8 cycles after each accepted start;
  - sum is stable between done pulses.
- With SERIAL_SUB_EN, N=4:
  - sub=1, a=5, b=3 gives sum=2, cout=1.
  - sub=1, a=3, b=5 gives sum=4'hE, cout=0.
  - sub=0 matches the add results above.
